// File: rtl/mdbrot_zoom_engine.sv
// mdbrot_zoom_engine: renders an H_RES x V_RES Mandelbrot view one pixel at a time
// around a programmable centre. The zoom level is a power-of-two right shift of the
// per-pixel step. Each pixel is handed to a ready/valid plot sink.
module mdbrot_zoom_engine #(
  parameter int H_RES    = 160,
  parameter int V_RES    = 120,
  parameter int DATA_W   = 32,
  parameter int FRAC     = 24,
  parameter int ITER_W   = 13,
  parameter int COLOUR_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ITER_W-1:0]          max_iter,
  input  logic [DATA_W-1:0]          center_x,
  input  logic [DATA_W-1:0]          center_y,
  input  logic [DATA_W-1:0]          base_step,
  input  logic [3:0]                 zoom,
  input  logic                       plot_ready,
  output logic [$clog2(H_RES)-1:0]   vga_x,
  output logic [$clog2(V_RES)-1:0]   vga_y,
  output logic [COLOUR_W-1:0]        vga_colour,
  output logic                       vga_plot,
  output logic                       busy,
  output logic                       done
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam int PW = 2 * DATA_W;
  localparam logic [XW-1:0]     X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(V_RES - 1);
  localparam logic [DATA_W-1:0] HALF_H = DATA_W'(H_RES / 2);
  localparam logic [DATA_W-1:0] HALF_V = DATA_W'(V_RES / 2);
  // Escape bound 4.0 at product scale (2*FRAC fractional bits), compared unsigned
  // because both squares are non-negative and their sum can reach 2^63.
  localparam logic [PW-1:0]     ESC_LIM = PW'(4) << (2 * FRAC);

  typedef enum logic [2:0] {
    S_IDLE, S_SCALE, S_INIT, S_ITER, S_PLOT, S_DONE
  } state_t;

  // Keep the Q(DATA_W-FRAC).FRAC window of a full-width product.
  function automatic logic signed [DATA_W-1:0] fx_trunc(input logic signed [PW-1:0] p);
    return DATA_W'(p >>> FRAC);
  endfunction

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  cen_x_q, cen_x_d, cen_y_q, cen_y_d;
  logic [DATA_W-1:0]         bstep_q, bstep_d, step_q, step_d;
  logic [3:0]                zoom_q, zoom_d;
  logic [ITER_W-1:0]         maxit_q, maxit_d, iter_q, iter_d;
  logic signed [DATA_W-1:0]  xmin_q, xmin_d, cx_q, cx_d, cy_q, cy_d;
  logic signed [DATA_W-1:0]  zr_q, zr_d, zi_q, zi_d;
  logic [XW-1:0]             px_q, px_d;
  logic [YW-1:0]             py_q, py_d;
  logic [COLOUR_W-1:0]       colour_q, colour_d;
  logic                      plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic signed [PW-1:0]      zr_sq, zi_sq, zrzi;
  logic [PW-1:0]             mag;
  logic                      escape;
  logic signed [DATA_W-1:0]  zr_next, zi_next;

  // Iteration datapath: full-width products, escape test and next z value.
  always_comb begin
    zr_sq   = PW'(zr_q) * PW'(zr_q);
    zi_sq   = PW'(zi_q) * PW'(zi_q);
    zrzi    = PW'(zr_q) * PW'(zi_q);
    mag     = zr_sq + zi_sq;
    escape  = (mag > ESC_LIM) || (iter_q == maxit_q);
    zr_next = fx_trunc(zr_sq) - fx_trunc(zi_sq) + cx_q;
    zi_next = fx_trunc(zrzi <<< 1) + cy_q;
  end

  // Frame sequencing: next state, scan position and registered outputs.
  always_comb begin
    state_d  = state_q;
    cen_x_d  = cen_x_q;
    cen_y_d  = cen_y_q;
    bstep_d  = bstep_q;
    zoom_d   = zoom_q;
    maxit_d  = maxit_q;
    step_d   = step_q;
    xmin_d   = xmin_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    px_d     = px_q;
    py_d     = py_q;
    zr_d     = zr_q;
    zi_d     = zi_q;
    iter_d   = iter_q;
    colour_d = colour_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cen_x_d = $signed(center_x);
          cen_y_d = $signed(center_y);
          bstep_d = base_step;
          zoom_d  = zoom;
          maxit_d = max_iter;
          state_d = S_SCALE;
        end
      end
      S_SCALE: begin
        step_d  = bstep_q >> zoom_q;
        xmin_d  = cen_x_q - $signed(step_d * HALF_H);
        cx_d    = xmin_d;
        cy_d    = cen_y_q + $signed(step_d * HALF_V);
        px_d    = '0;
        py_d    = '0;
        state_d = S_INIT;
      end
      S_INIT: begin
        zr_d    = '0;
        zi_d    = '0;
        iter_d  = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (escape) begin
          colour_d = (iter_q == maxit_q) ? '0 : iter_q[COLOUR_W-1:0];
          state_d  = S_PLOT;
        end else begin
          zr_d   = zr_next;
          zi_d   = zi_next;
          iter_d = iter_q + ITER_W'(1);
        end
      end
      S_PLOT: begin
        if (plot_ready) begin
          if (px_q == X_LAST) begin
            if (py_q == Y_LAST) begin
              state_d = S_DONE;
            end else begin
              px_d    = '0;
              cx_d    = xmin_q;
              py_d    = py_q + YW'(1);
              cy_d    = cy_q - $signed(step_q);
              state_d = S_INIT;
            end
          end else begin
            px_d    = px_q + XW'(1);
            cx_d    = cx_q + $signed(step_q);
            state_d = S_INIT;
          end
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    plot_d = (state_d == S_PLOT);
    busy_d = (state_d == S_SCALE) || (state_d == S_INIT) ||
             (state_d == S_ITER)  || (state_d == S_PLOT);
    done_d = (state_d == S_DONE);
  end

  // State register: control and visible outputs reset, working data just loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      px_q     <= '0;
      py_q     <= '0;
      iter_q   <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      iter_q   <= iter_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
    cen_x_q <= cen_x_d;
    cen_y_q <= cen_y_d;
    bstep_q <= bstep_d;
    zoom_q  <= zoom_d;
    maxit_q <= maxit_d;
    step_q  <= step_d;
    xmin_q  <= xmin_d;
    cx_q    <= cx_d;
    cy_q    <= cy_d;
    zr_q    <= zr_d;
    zi_q    <= zi_d;
  end

  assign vga_x      = px_q;
  assign vga_y      = py_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mdbrot_zoom_engine.sv
// Bench for mdbrot_zoom_engine on a 4x2 Q8.24 frame, against an arithmetic
// reference model of the escape-time rule.
module tb_mdbrot_zoom_engine;

  localparam int NPIX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, plot_ready;
  logic [12:0] max_iter;
  logic [31:0] center_x, center_y, base_step;
  logic [3:0]  zoom;
  logic [1:0]  vga_x;
  logic [0:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy, done;

  mdbrot_zoom_engine #(
    .H_RES(4), .V_RES(2), .DATA_W(32), .FRAC(24), .ITER_W(13), .COLOUR_W(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .max_iter(max_iter),
    .center_x(center_x), .center_y(center_y), .base_step(base_step),
    .zoom(zoom), .plot_ready(plot_ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  int got_x[NPIX], got_y[NPIX], got_c[NPIX], got_cyc[NPIX];
  int n_plots, start_cyc;
  bit done_seen;
  int exp_x[NPIX], exp_y[NPIX], exp_c[NPIX], exp_upd[NPIX];

  // Escape-time count for c = cr + i*ci in Q8.24: number of z updates before
  // |z|^2 > 4 or the iteration limit is reached.
  function automatic int model_iters(input int cr, input int ci, input int mi);
    int zr, zi, zr_n, zi_n;
    longint rr, ii, ri;
    longint unsigned m;
    zr = 0;
    zi = 0;
    for (int it = 0; it <= mi; it++) begin
      rr = longint'(zr) * longint'(zr);
      ii = longint'(zi) * longint'(zi);
      m  = rr + ii;
      if (m > (64'd4 << 48) || it == mi) return it;
      ri   = longint'(zr) * longint'(zi);
      zr_n = int'(rr >>> 24) - int'(ii >>> 24) + cr;
      zi_n = int'((ri * 2) >>> 24) + ci;
      zr   = zr_n;
      zi   = zi_n;
    end
    return mi;
  endfunction

  // Whole-frame expectation: pixel (x,y) sits at c = (xmin + x*step, ymax - y*step).
  function automatic void model_frame(input int cx0, input int cy0, input int unsigned bs,
                                      input int zm, input int mi);
    int unsigned step;
    int xmin, ymax, x, y, cr, ci;
    step = bs >> zm;
    xmin = cx0 - int'(step * 2);
    ymax = cy0 + int'(step);
    for (int k = 0; k < NPIX; k++) begin
      x  = k % 4;
      y  = k / 4;
      cr = xmin + x * int'(step);
      ci = ymax - y * int'(step);
      exp_x[k]   = x;
      exp_y[k]   = y;
      exp_upd[k] = model_iters(cr, ci, mi);
      exp_c[k]   = (exp_upd[k] == mi) ? 0 : (exp_upd[k] % 8);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; start = 1'b0; plot_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic launch(input logic [31:0] cx, input logic [31:0] cy, input logic [31:0] bs,
                        input logic [3:0] zm, input logic [12:0] mi);
    center_x = cx; center_y = cy; base_step = bs; zoom = zm; max_iter = mi;
    start = 1'b1;
    model_frame($signed(cx), $signed(cy), bs, int'(zm), int'(mi));
  endtask

  // Record every accepted pixel and the sample index it was offered on, until done.
  task automatic capture_frame(input int budget, input bit scramble);
    n_plots = 0; start_cyc = -1; done_seen = 1'b0;
    for (int k = 0; k < NPIX; k++) begin
      got_x[k] = -1; got_y[k] = -1; got_c[k] = -1; got_cyc[k] = -1;
    end
    for (int c = 0; c < budget; c++) begin
      tick();
      if (scramble && c == 1) begin
        center_x = $urandom; center_y = $urandom; base_step = $urandom;
        zoom = 4'($urandom); max_iter = 13'($urandom);
      end
      if (busy && start_cyc < 0) start_cyc = c;
      if (vga_plot && plot_ready && n_plots < NPIX) begin
        got_x[n_plots] = int'(vga_x); got_y[n_plots] = int'(vga_y);
        got_c[n_plots] = int'(vga_colour); got_cyc[n_plots] = c;
        n_plots++;
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_frame();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; plot_ready = 1'b0;
    center_x = '0; center_y = '0; base_step = '0; zoom = '0; max_iter = '0;
    repeat (3) tick();
    total++; if (vga_plot !== 1'b0) begin bad++; $display("FAIL reset_plot got=%0d exp=0", vga_plot); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", done); end
    total++; if (vga_x !== 2'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", vga_x); end
    total++; if (vga_y !== 1'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", vga_y); end
    total++; if (vga_colour !== 3'd0) begin bad++; $display("FAIL reset_colour got=%0d exp=0", vga_colour); end
    rst = 1'b0;
    plot_ready = 1'b1;
    repeat (3) tick();
    total++;
    if (busy !== 1'b0 || vga_plot !== 1'b0) begin
      bad++; $display("FAIL idle_without_start got busy=%0d plot=%0d exp 0 0", busy, vga_plot);
    end
  endtask

  task automatic test_scale();
    int gap;
    pulse_reset();
    launch(32'h0, 32'h0, 32'h0100_0000, 4'd0, 13'd8);
    plot_ready = 1'b1;
    capture_frame(600, 1'b0);
    total++; if (start_cyc !== 0) begin bad++; $display("FAIL scale_busy_latency got=%0d exp=0", start_cyc); end
    total++;
    if (n_plots !== NPIX || !done_seen) begin
      bad++; $display("FAIL scale_count got=%0d done=%0d exp=%0d done=1", n_plots, done_seen, NPIX);
    end
    total++; if (got_c[0] !== 1) begin bad++; $display("FAIL scale_first_colour got=%0d exp=1", got_c[0]); end
    for (int k = 0; k < NPIX; k++) begin
      gap = got_cyc[k] - ((k == 0) ? start_cyc : got_cyc[k-1]);
      total++;
      if (got_x[k] !== exp_x[k] || got_y[k] !== exp_y[k] || got_c[k] !== exp_c[k] || gap !== exp_upd[k] + 3) begin
        bad++;
        $display("FAIL scale_pix%0d got=(%0d,%0d) col=%0d gap=%0d exp=(%0d,%0d) col=%0d gap=%0d",
                 k, got_x[k], got_y[k], got_c[k], gap, exp_x[k], exp_y[k], exp_c[k], exp_upd[k] + 3);
      end
    end
  endtask

  // Runs straight after test_scale with start still high.
  task automatic test_hold_start();
    int viol;
    viol = 0;
    repeat (20) begin
      tick();
      if (done !== 1'b1 || busy !== 1'b0 || vga_plot !== 1'b0) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL hold_no_second_frame got=%0d bad cycles exp=0", viol); end
    start = 1'b0;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL hold_back_to_idle got done=%0d busy=%0d exp 0 0", done, busy);
    end
    start = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_restart_busy got=%0d exp=1", busy); end
    capture_frame(600, 1'b0);
    total++;
    if (n_plots !== NPIX || !done_seen) begin
      bad++; $display("FAIL hold_restart_count got=%0d done=%0d exp=%0d done=1", n_plots, done_seen, NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      total++;
      if (got_x[k] !== exp_x[k] || got_y[k] !== exp_y[k] || got_c[k] !== exp_c[k]) begin
        bad++;
        $display("FAIL hold_pix%0d got=(%0d,%0d) col=%0d exp=(%0d,%0d) col=%0d",
                 k, got_x[k], got_y[k], got_c[k], exp_x[k], exp_y[k], exp_c[k]);
      end
    end
    finish_frame();
  endtask

  task automatic test_zoom();
    int gap;
    pulse_reset();
    launch(32'h0, 32'h00C0_0000, 32'h0100_0000, 4'd2, 13'd8);
    plot_ready = 1'b1;
    capture_frame(600, 1'b0);
    total++;
    if (n_plots !== NPIX || !done_seen) begin
      bad++; $display("FAIL zoom_count got=%0d done=%0d exp=%0d done=1", n_plots, done_seen, NPIX);
    end
    gap = got_cyc[6] - got_cyc[5];
    total++;
    if (got_x[6] !== 2 || got_y[6] !== 1 || got_c[6] !== 0 || gap !== 11) begin
      bad++; $display("FAIL zoom_in_set got=(%0d,%0d) col=%0d gap=%0d exp=(2,1) col=0 gap=11",
                      got_x[6], got_y[6], got_c[6], gap);
    end
    for (int k = 0; k < NPIX; k++) begin
      gap = got_cyc[k] - ((k == 0) ? start_cyc : got_cyc[k-1]);
      total++;
      if (got_x[k] !== exp_x[k] || got_y[k] !== exp_y[k] || got_c[k] !== exp_c[k] || gap !== exp_upd[k] + 3) begin
        bad++;
        $display("FAIL zoom_pix%0d got=(%0d,%0d) col=%0d gap=%0d exp=(%0d,%0d) col=%0d gap=%0d",
                 k, got_x[k], got_y[k], got_c[k], gap, exp_x[k], exp_y[k], exp_c[k], exp_upd[k] + 3);
      end
    end
    finish_frame();
  endtask

  task automatic test_backpressure();
    bit seen;
    int unstable;
    logic [1:0] sx;
    logic [0:0] sy;
    logic [2:0] sc;
    pulse_reset();
    launch(32'h0040_0000, 32'hFFC0_0000, 32'h0100_0000, 4'd1, 13'd6);
    plot_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (vga_plot) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_first_plot got=timeout exp=plot"); end
    sx = vga_x; sy = vga_y; sc = vga_colour;
    total++;
    if (int'(sx) !== exp_x[0] || int'(sy) !== exp_y[0] || int'(sc) !== exp_c[0]) begin
      bad++; $display("FAIL bp_first_pixel got=(%0d,%0d) col=%0d exp=(%0d,%0d) col=%0d",
                      sx, sy, sc, exp_x[0], exp_y[0], exp_c[0]);
    end
    unstable = 0;
    repeat (5) begin
      tick();
      if (vga_plot !== 1'b1 || vga_x !== sx || vga_y !== sy || vga_colour !== sc) unstable++;
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d moving cycles exp=0", unstable); end
    plot_ready = 1'b1;
    tick();
    plot_ready = 1'b0;
    total++;
    if (vga_plot !== 1'b0 || vga_x !== 2'd1 || vga_y !== 1'd0) begin
      bad++; $display("FAIL bp_advance got plot=%0d x=%0d y=%0d exp plot=0 x=1 y=0", vga_plot, vga_x, vga_y);
    end
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (vga_plot) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || vga_x !== 2'd1 || vga_y !== 1'd0 || int'(vga_colour) !== exp_c[1]) begin
      bad++; $display("FAIL bp_second_pixel got seen=%0d x=%0d y=%0d col=%0d exp seen=1 x=1 y=0 col=%0d",
                      seen, vga_x, vga_y, vga_colour, exp_c[1]);
    end
    plot_ready = 1'b1;
    capture_frame(600, 1'b0);
    total++;
    if (n_plots !== NPIX - 2 || !done_seen) begin
      bad++; $display("FAIL bp_rest_count got=%0d done=%0d exp=%0d done=1", n_plots, done_seen, NPIX - 2);
    end
    for (int k = 0; k < NPIX - 2; k++) begin
      total++;
      if (got_x[k] !== exp_x[k+2] || got_y[k] !== exp_y[k+2] || got_c[k] !== exp_c[k+2]) begin
        bad++;
        $display("FAIL bp_pix%0d got=(%0d,%0d) col=%0d exp=(%0d,%0d) col=%0d",
                 k + 2, got_x[k], got_y[k], got_c[k], exp_x[k+2], exp_y[k+2], exp_c[k+2]);
      end
    end
    finish_frame();
  endtask

  task automatic test_maxiter0();
    int gap;
    logic [31:0] cx, cy;
    pulse_reset();
    cx = 32'($urandom_range(0, 32'h0300_0000)) - 32'h0180_0000;
    cy = 32'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000;
    launch(cx, cy, 32'($urandom_range(32'h0010_0000, 32'h0100_0000)), 4'($urandom_range(0, 3)), 13'd0);
    plot_ready = 1'b1;
    capture_frame(200, 1'b0);
    total++;
    if (n_plots !== NPIX || !done_seen) begin
      bad++; $display("FAIL mi0_count got=%0d done=%0d exp=%0d done=1", n_plots, done_seen, NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      gap = got_cyc[k] - ((k == 0) ? start_cyc : got_cyc[k-1]);
      total++;
      if (got_x[k] !== exp_x[k] || got_y[k] !== exp_y[k] || got_c[k] !== 0 || gap !== 3) begin
        bad++;
        $display("FAIL mi0_pix%0d got=(%0d,%0d) col=%0d gap=%0d exp=(%0d,%0d) col=0 gap=3",
                 k, got_x[k], got_y[k], got_c[k], gap, exp_x[k], exp_y[k]);
      end
    end
    finish_frame();
  endtask

  task automatic test_reset_mid();
    int cnt;
    pulse_reset();
    launch(32'h0, 32'h0, 32'h0100_0000, 4'd0, 13'd8);
    plot_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (vga_plot) cnt++;
      if (cnt == 3) break;
    end
    tick();
    total++;
    if (cnt !== 3 || vga_x !== 2'd3 || busy !== 1'b1) begin
      bad++; $display("FAIL rmid_reach_pix3 got plots=%0d x=%0d busy=%0d exp plots=3 x=3 busy=1", cnt, vga_x, busy);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (vga_plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || vga_x !== 2'd0 || vga_y !== 1'd0 || vga_colour !== 3'd0) begin
      bad++; $display("FAIL rmid_outputs got plot=%0d busy=%0d done=%0d x=%0d y=%0d col=%0d exp all 0",
                      vga_plot, busy, done, vga_x, vga_y, vga_colour);
    end
    capture_frame(600, 1'b0);
    total++;
    if (start_cyc !== 0 || n_plots !== NPIX || !done_seen) begin
      bad++; $display("FAIL rmid_restart got start=%0d plots=%0d done=%0d exp start=0 plots=%0d done=1",
                      start_cyc, n_plots, done_seen, NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      total++;
      if (got_x[k] !== exp_x[k] || got_y[k] !== exp_y[k] || got_c[k] !== exp_c[k]) begin
        bad++;
        $display("FAIL rmid_pix%0d got=(%0d,%0d) col=%0d exp=(%0d,%0d) col=%0d",
                 k, got_x[k], got_y[k], got_c[k], exp_x[k], exp_y[k], exp_c[k]);
      end
    end
    finish_frame();
  endtask

  task automatic test_random();
    int gap;
    logic [31:0] cx, cy;
    for (int f = 0; f < 6; f++) begin
      pulse_reset();
      cx = 32'($urandom_range(0, 32'h0300_0000)) - 32'h0180_0000;
      cy = 32'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000;
      launch(cx, cy, 32'($urandom_range(32'h0010_0000, 32'h0100_0000)),
             4'($urandom_range(0, 4)), 13'($urandom_range(0, 20)));
      plot_ready = 1'b1;
      capture_frame(800, 1'b1);
      total++;
      if (start_cyc !== 0 || n_plots !== NPIX || !done_seen) begin
        bad++; $display("FAIL rnd%0d_frame got start=%0d plots=%0d done=%0d exp start=0 plots=%0d done=1",
                        f, start_cyc, n_plots, done_seen, NPIX);
      end
      for (int k = 0; k < NPIX; k++) begin
        gap = got_cyc[k] - ((k == 0) ? start_cyc : got_cyc[k-1]);
        total++;
        if (got_x[k] !== exp_x[k] || got_y[k] !== exp_y[k] || got_c[k] !== exp_c[k] || gap !== exp_upd[k] + 3) begin
          bad++;
          $display("FAIL rnd%0d_pix%0d got=(%0d,%0d) col=%0d gap=%0d exp=(%0d,%0d) col=%0d gap=%0d",
                   f, k, got_x[k], got_y[k], got_c[k], gap, exp_x[k], exp_y[k], exp_c[k], exp_upd[k] + 3);
        end
      end
      finish_frame();
    end
  endtask

  initial begin
    test_reset();
    test_scale();
    test_hold_start();
    test_zoom();
    test_backpressure();
    test_maxiter0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdbrot_zoom_engine.md
MDBROT_ZOOM_ENGINE -- requirements
Module: mdbrot_zoom_engine

Interface
REQ-001 SHALL have parameter H_RES, default 160, meaning horizontal pixel count.
REQ-002 SHALL have parameter V_RES, default 120, meaning vertical pixel count.
REQ-003 SHALL have parameter DATA_W, default 32, meaning signed fixed-point word width.
REQ-004 SHALL have parameter FRAC, default 24, meaning fractional bits (Q(DATA_W-FRAC).FRAC).
REQ-005 SHALL have parameter ITER_W, default 13, meaning iteration counter width.
REQ-006 SHALL have parameter COLOUR_W, default 3, meaning colour output width.
REQ-007 SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-008 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  level request to render a frame.
- max_iter  in  ITER_W  iteration limit.
- center_x, center_y  in  DATA_W  signed view centre.
- base_step  in  DATA_W  unsigned per-pixel step at zoom 0.
- zoom  in  4  right-shift applied to base_step.
- plot_ready  in  1  sink accepts the pixel.
- vga_x  out  $clog2(H_RES)  pixel column.
- vga_y  out  $clog2(V_RES)  pixel row.
- vga_colour  out  COLOUR_W  pixel colour.
- vga_plot  out  1  pixel valid.
- busy  out  1  frame in progress.
- done  out  1  frame complete.

Function
REQ-009 SHALL implement the states IDLE, SCALE, INIT, ITER, PLOT and DONE.
REQ-010 IDLE: when start=1, SHALL register center_x, center_y, base_step, zoom and max_iter, then go to SCALE; later input changes SHALL NOT affect the current frame.
REQ-011 SCALE (1 cycle): SHALL compute:
- step = base_step >> zoom.
- xmin = center_x - step*(H_RES/2).
- ymax = center_y + step*(V_RES/2).
- px=0, py=0, cx=xmin, cy=ymax.
SCALE SHALL then go to INIT.
REQ-012 INIT (1 cycle): SHALL set zr=0, zi=0, iter=0, then go to ITER.
REQ-013 ITER: SHALL perform one check per cycle.
- Escape when zr^2+zi^2 > 4.0, or when iter==max_iter; on escape go to PLOT.
- Otherwise zr <= zr^2-zi^2+cx, zi <= 2*zr*zi+cy, iter <= iter+1.
REQ-014 Products SHALL be computed at full 2*DATA_W signed width and truncated to bits [FRAC+DATA_W-1:FRAC]; the magnitude compare SHALL be done at 2*DATA_W width without truncation.
REQ-015 Colour SHALL be 0 when iter==max_iter at escape, otherwise iter[COLOUR_W-1:0].
REQ-016 PLOT: SHALL set vga_plot=1, with vga_x=px, vga_y=py and vga_colour held stable until plot_ready=1 is sampled in PLOT.
REQ-017 On acceptance, px SHALL increment and cx += step.
- When px==H_RES-1: px=0, cx=xmin, py increments and cy -= step.
- After pixel (H_RES-1, V_RES-1): go to DONE.
- Otherwise: go to INIT.
REQ-018 vga_plot SHALL be 1 only in PLOT, and at most one pixel SHALL be accepted per plot_ready cycle.
REQ-019 busy SHALL be 1 in SCALE, INIT, ITER and PLOT.
REQ-020 done SHALL be 1 only in DONE; DONE SHALL return to IDLE when start=0, so a held start renders exactly one frame.
REQ-021 If max_iter=0, every pixel SHALL escape on its first ITER cycle with colour 0.
REQ-022 start changes while busy SHALL be ignored.
REQ-023 plot_ready outside PLOT SHALL be ignored.

Reset
REQ-024 On rst=1, SHALL go to IDLE and clear vga_plot, busy, done, vga_x, vga_y, vga_colour, px, py and iter to 0, from any state including mid-frame.
REQ-025 rst SHALL take priority over start and plot_ready in the same cycle.

Verification
REQ-026 Bench SHALL run with H_RES=4, V_RES=2, FRAC=24, DATA_W=32 and cover:
- Scale check: center=(0,0), base_step=0x01000000, zoom=0, max_iter=8, plot_ready=1 -> first pixel (0,0) has c=(-2.0,+1.0) and colour 1; 8 plots in raster order (0,0),(1,0),(2,0),(3,0),(0,1)...(3,1); then done=1.
- Zoom and in-set: zoom=2 -> step=0x00400000 and xmin=-0.5; pixel (2,1) has c=(0,0.75) and max_iter=8 -> colour 0 after exactly 8 updates (first plot cycle = INIT + 9 ITER cycles).
- Back-pressure: plot_ready held low 5 cycles in PLOT -> vga_plot, vga_x, vga_y and vga_colour stable for all 5 cycles; exactly one pixel advance on release.
- max_iter=0 -> all 8 pixels colour 0, each 3 cycles (INIT, ITER, PLOT) with plot_ready=1.
- Reset mid-frame: rst pulsed during ITER of pixel 3 -> next cycle IDLE, all outputs 0; with start held high, the next frame restarts at (0,0).
- Start held high through DONE -> no second frame; start low for 1 cycle then high -> new frame begins with busy=1 two cycles later.
